// File: rtl/rst_sequencer.sv
// Start-up/reset sequencer: synchronises lock and button, debounces the button, and holds
// rst_out for HOLD_CYCLES after lock. Define RST_SEQ_LOCK_LOSS_EN to re-enter reset on lock loss in RUN.
module rst_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       locked_async,
  output logic       rst_out,
  output logic       ready,
  output logic [1:0] rst_cause
);

  // state     | meaning
  // WAIT_LOCK | clock not locked, reset asserted
  // HOLD      | locked, counting hold cycles before release
  // RUN       | reset released, functional top running
  // BTN       | button held, reset asserted until release
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN, BTN} state_t;

  // +1 keeps both widths non-zero and able to hold the terminal value
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   w_lock_s;
  logic                   w_btn_s;
  logic                   r_btn_db;
  logic [DB_W-1:0]        r_db_cnt;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic                   r_rst_out;
  logic                   r_ready;
  logic [1:0]             r_rst_cause;

  assign w_lock_s  = r_lock_sync[SYNC_STAGES-1];
  assign w_btn_s   = r_btn_sync[SYNC_STAGES-1];
  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign rst_cause = r_rst_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_sync <= '0;
      r_btn_sync  <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked_async};
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_btn_db <= ~r_btn_db;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_btn_db) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        if (r_btn_db) begin
          w_state_nxt = BTN;
        end
`ifdef RST_SEQ_LOCK_LOSS_EN
        else if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end
`endif
      end
      BTN: begin
        if (!r_btn_db) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Outputs are registered from next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_LOCK;
      r_hold_cnt  <= '0;
      r_rst_out   <= 1'b1;
      r_ready     <= 1'b0;
      r_rst_cause <= 2'b01;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rst_out  <= (w_state_nxt != RUN);
      r_ready    <= (w_state_nxt == RUN);
      if (r_state == RUN && w_state_nxt != RUN) begin
        r_rst_cause <= (w_state_nxt == BTN) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: per-cycle comparison against a behavioural
// model plus literal edge-count checks. Honours RST_SEQ_LOCK_LOSS_EN like the design.
module tb_rst_sequencer;

  localparam int S   = 2;
  localparam int DEB = 8;
  localparam int H   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       locked_async;
  logic       rst_out;
  logic       ready;
  logic [1:0] rst_cause;

  int n_checks = 0;
  int n_errors = 0;

  rst_sequencer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .locked_async (locked_async),
    .rst_out      (rst_out),
    .ready        (ready),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: delay lines for the synchronisers, run-length debounce,
  // and a few flags describing where the sequence currently is.
  bit m_valid = 0;
  bit q_lock[$];
  bit q_btn[$];
  bit m_db, m_in_run, m_btn_phase, m_waiting;
  int m_diff, m_hold_done;
  bit m_rst_out, m_ready;
  int m_cause;
  bit L, Bs, B;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q_lock = {};
        q_btn  = {};
        for (int i = 0; i < S; i++) begin
          q_lock.push_back(1'b0);
          q_btn.push_back(1'b0);
        end
        m_db = 0; m_diff = 0;
        m_waiting = 1; m_in_run = 0; m_btn_phase = 0; m_hold_done = 0;
        m_cause = 1; m_rst_out = 1; m_ready = 0;
        m_valid = 1;
      end else if (m_valid) begin
        L  = q_lock[0];
        Bs = q_btn[0];
        B  = m_db;
        void'(q_lock.pop_front());
        void'(q_btn.pop_front());
        q_lock.push_back(locked_async);
        q_btn.push_back(btn_raw);
        if (Bs != m_db) begin
          m_diff++;
          if (m_diff == DEB) begin
            m_db = !m_db;
            m_diff = 0;
          end
        end else begin
          m_diff = 0;
        end
        if (m_in_run) begin
          if (B) begin
            m_in_run = 0; m_btn_phase = 1; m_cause = 2;
          end
`ifdef RST_SEQ_LOCK_LOSS_EN
          else if (!L) begin
            m_in_run = 0; m_waiting = 1; m_cause = 1;
          end
`endif
        end else if (m_btn_phase) begin
          if (!B) begin
            m_btn_phase = 0; m_hold_done = 0;
          end
        end else if (m_waiting) begin
          if (L) begin
            m_waiting = 0; m_hold_done = 0;
          end
        end else begin
          if (!L) m_waiting = 1;
          else if (B) m_hold_done = 0;
          else if (m_hold_done == H - 1) m_in_run = 1;
          else m_hold_done++;
        end
        m_rst_out = !m_in_run;
        m_ready   = m_in_run;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("cyc_rst_out", {31'd0, rst_out}, {31'd0, m_rst_out});
        check("cyc_ready", {31'd0, ready}, {31'd0, m_ready});
        check("cyc_rst_cause", {30'd0, rst_cause}, m_cause);
      end
    end
  end

  initial begin
    rst = 1'b1; locked_async = 1'b1; btn_raw = 1'b0;
    wait_edges(1);
    check("rst_rst_out", {31'd0, rst_out}, 1);
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_cause", {30'd0, rst_cause}, 1);
    wait_edges(2);
    rst = 1'b0;

    // boot: release 7 edges after rst drops
    wait_edges(6);
    check("boot_still_held", {31'd0, rst_out}, 1);
    wait_edges(1);
    check("boot_rst_out", {31'd0, rst_out}, 0);
    check("boot_ready", {31'd0, ready}, 1);
    check("boot_cause", {30'd0, rst_cause}, 1);

    // short glitch is filtered
    btn_raw = 1'b1;
    wait_edges(5);
    btn_raw = 1'b0;
    wait_edges(20);
    check("glitch_rst_out", {31'd0, rst_out}, 0);
    check("glitch_ready", {31'd0, ready}, 1);

    // long press: reset 11 edges after press, release 15 edges after let-go
    btn_raw = 1'b1;
    wait_edges(10);
    check("press_not_yet", {31'd0, rst_out}, 0);
    wait_edges(1);
    check("press_rst_out", {31'd0, rst_out}, 1);
    check("press_cause", {30'd0, rst_cause}, 2);
    wait_edges(9);
    btn_raw = 1'b0;
    wait_edges(14);
    check("release_still_held", {31'd0, rst_out}, 1);
    wait_edges(1);
    check("release_rst_out", {31'd0, rst_out}, 0);
    check("release_ready", {31'd0, ready}, 1);
    check("release_cause_kept", {30'd0, rst_cause}, 2);

    // lock loss while running
    locked_async = 1'b0;
    wait_edges(2);
    check("lockloss_early", {31'd0, rst_out}, 0);
    wait_edges(1);
`ifdef RST_SEQ_LOCK_LOSS_EN
    check("lockloss_rst_out", {31'd0, rst_out}, 1);
    check("lockloss_cause", {30'd0, rst_cause}, 1);
`else
    check("lockloss_ignored", {31'd0, rst_out}, 0);
    check("lockloss_ready", {31'd0, ready}, 1);
`endif
    wait_edges(2);
    locked_async = 1'b1;
    wait_edges(12);
    check("relock_ready", {31'd0, ready}, 1);

    // lock drop during HOLD restarts the full hold
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    wait_edges(3);
    locked_async = 1'b0;
    wait_edges(3);
    locked_async = 1'b1;
    wait_edges(6);
    check("holddrop_still_held", {31'd0, rst_out}, 1);
    wait_edges(1);
    check("holddrop_rst_out", {31'd0, rst_out}, 0);
    check("holddrop_cause", {30'd0, rst_cause}, 1);

    // no lock for 100 cycles
    locked_async = 1'b0;
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    wait_edges(100);
    check("nolock_rst_out", {31'd0, rst_out}, 1);
    check("nolock_ready", {31'd0, ready}, 0);
    locked_async = 1'b1;
    wait_edges(6);
    check("latelock_held", {31'd0, rst_out}, 1);
    wait_edges(1);
    check("latelock_ready", {31'd0, ready}, 1);

    // rst during BTN state
    btn_raw = 1'b1;
    wait_edges(12);
    check("btn_state_rst_out", {31'd0, rst_out}, 1);
    check("btn_state_cause", {30'd0, rst_cause}, 2);
    rst = 1'b1;
    wait_edges(1);
    check("midrst_rst_out", {31'd0, rst_out}, 1);
    check("midrst_ready", {31'd0, ready}, 0);
    check("midrst_cause", {30'd0, rst_cause}, 1);
    btn_raw = 1'b0;
    rst = 1'b0;
    wait_edges(30);
    check("final_ready", {31'd0, ready}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
